// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller: prices,
// item codes, one-hot item encodings, FSM states and change denominations.
package vend_pkg;

  localparam logic [7:0] DEF_PRICE_CHOC  = 8'd5;
  localparam logic [7:0] DEF_PRICE_CHIPS = 8'd10;
  localparam logic [7:0] DEF_PRICE_DRINK = 8'd20;
  localparam logic [7:0] DEF_PRICE_ICE   = 8'd50;
  localparam int         DEF_TIMEOUT_CYCLES = 1000;

  localparam logic [1:0] ITEM_CHOC  = 2'b00;
  localparam logic [1:0] ITEM_CHIPS = 2'b01;
  localparam logic [1:0] ITEM_DRINK = 2'b10;
  localparam logic [1:0] ITEM_ICE   = 2'b11;

  localparam logic [3:0] ITEM_OH_CHOC  = 4'b0001;
  localparam logic [3:0] ITEM_OH_CHIPS = 4'b0010;
  localparam logic [3:0] ITEM_OH_DRINK = 4'b0100;
  localparam logic [3:0] ITEM_OH_ICE   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  // Index 4 holds the largest coin, index 0 the smallest.
  localparam int NUM_DENOMS = 5;
  localparam logic [NUM_DENOMS-1:0][7:0] CHANGE_DENOMS =
    {8'd20, 8'd10, 8'd5, 8'd2, 8'd1};

  // Maps an item code onto the one-hot dispenser select lines.
  function automatic logic [3:0] itemOneHot(input logic [1:0] item);
    case (item)
      ITEM_CHOC:  return ITEM_OH_CHOC;
      ITEM_CHIPS: return ITEM_OH_CHIPS;
      ITEM_DRINK: return ITEM_OH_DRINK;
      default:    return ITEM_OH_ICE;
    endcase
  endfunction

endpackage

// File: rtl/vend_txn_controller_if.sv
// Front-end / actuator signal bundle for the vending transaction controller.
// The slave side is the controller; the master side is the surrounding system.
interface vend_txn_controller_if;

  logic       coin_valid;
  logic [7:0] coin_value;
  logic       select_valid;
  logic [1:0] select;
  logic       cancel;
  logic       vend_done;
  logic       change_ack;

  logic       coin_accept;
  logic       coin_reject;
  logic       err_insufficient;
  logic       vend_req;
  logic [3:0] vend_item;
  logic       change_req;
  logic [7:0] change_coin;
  logic [7:0] credit;
  logic       busy;

  modport master (
    output coin_valid, coin_value, select_valid, select, cancel,
           vend_done, change_ack,
    input  coin_accept, coin_reject, err_insufficient, vend_req, vend_item,
           change_req, change_coin, credit, busy
  );

  modport slave (
    input  coin_valid, coin_value, select_valid, select, cancel,
           vend_done, change_ack,
    output coin_accept, coin_reject, err_insufficient, vend_req, vend_item,
           change_req, change_coin, credit, busy
  );

endinterface

// File: rtl/vend_change_sel.sv
// Greedy change picker: returns the largest denomination not exceeding
// the given credit, or 0 when there is nothing left to pay.
module vend_change_sel
  import vend_pkg::*;
(
  input  logic [7:0] credit_i,
  output logic [7:0] coin_o
);

  // Walk denominations smallest to largest so the last fit is the largest.
  always_comb begin
    coin_o = '0;
    for (int i = 0; i < NUM_DENOMS; i++) begin
      if (credit_i >= CHANGE_DENOMS[i]) begin
        coin_o = CHANGE_DENOMS[i];
      end
    end
  end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: accumulates coin credit, arbitrates
// cancel/select/coin/timeout, runs the dispense handshake and then pays
// change one coin at a time through the hopper handshake.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter logic [7:0] PRICE_CHOC     = DEF_PRICE_CHOC,
  parameter logic [7:0] PRICE_CHIPS    = DEF_PRICE_CHIPS,
  parameter logic [7:0] PRICE_DRINK    = DEF_PRICE_DRINK,
  parameter logic [7:0] PRICE_ICE      = DEF_PRICE_ICE,
  parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  vend_txn_controller_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [7:0]    credit_q, credit_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          coin_accept_q, coin_accept_d;
  logic          coin_reject_q, coin_reject_d;
  logic          err_q, err_d;
  logic          vend_req_q, vend_req_d;
  logic [3:0]    vend_item_q, vend_item_d;
  logic          change_req_q, change_req_d;
  logic [7:0]    change_coin_q, change_coin_d;
  logic          busy_q, busy_d;

  logic [8:0]    coinSum;
  logic          coinFits;
  logic          coinEvent;
  logic [7:0]    selPrice;
  logic [7:0]    changeCoinNext;

  function automatic logic [7:0] priceOf(input logic [1:0] item);
    case (item)
      ITEM_CHOC:  return PRICE_CHOC;
      ITEM_CHIPS: return PRICE_CHIPS;
      ITEM_DRINK: return PRICE_DRINK;
      default:    return PRICE_ICE;
    endcase
  endfunction

  assign coinSum   = {1'b0, credit_q} + {1'b0, bus.coin_value};
  assign coinFits  = (coinSum <= 9'd255);
  assign coinEvent = bus.coin_valid && (bus.coin_value != 8'd0);
  assign selPrice  = priceOf(bus.select);

  // Change coin is picked from the credit that will hold after this edge,
  // so the denomination is ready in the same cycle CHANGE is entered.
  vend_change_sel u_change_sel (
    .credit_i (credit_d),
    .coin_o   (changeCoinNext)
  );

  // Next-state logic: event arbitration, credit bookkeeping and output pulses.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    tcnt_d        = tcnt_q;
    coin_accept_d = 1'b0;
    coin_reject_d = 1'b0;
    err_d         = 1'b0;
    vend_req_d    = vend_req_q;
    vend_item_d   = vend_item_q;

    case (state_q)
      IDLE: begin
        if (coinEvent) begin
          if (coinFits) begin
            credit_d      = coinSum[7:0];
            coin_accept_d = 1'b1;
            tcnt_d        = '0;
            state_d       = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      CREDIT: begin
        if (bus.cancel) begin
          tcnt_d        = '0;
          coin_reject_d = coinEvent;
          state_d       = (credit_q != 8'd0) ? CHANGE : IDLE;
        end else if (bus.select_valid) begin
          tcnt_d        = '0;
          coin_reject_d = coinEvent;
          if (credit_q >= selPrice) begin
            credit_d    = credit_q - selPrice;
            vend_req_d  = 1'b1;
            vend_item_d = itemOneHot(bus.select);
            state_d     = VEND;
          end else begin
            err_d = 1'b1;
          end
        end else if (coinEvent) begin
          tcnt_d = '0;
          if (coinFits) begin
            credit_d      = coinSum[7:0];
            coin_accept_d = 1'b1;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (tcnt_q == TIMEOUT_LAST) begin
          tcnt_d  = '0;
          state_d = (credit_q != 8'd0) ? CHANGE : IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      VEND: begin
        coin_reject_d = coinEvent;
        if (bus.vend_done) begin
          vend_req_d  = 1'b0;
          vend_item_d = 4'b0000;
          state_d     = (credit_q != 8'd0) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        coin_reject_d = coinEvent;
        if (bus.change_ack) begin
          credit_d = credit_q - change_coin_q;
          if (credit_d == 8'd0) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    change_req_d  = (state_d == CHANGE);
    change_coin_d = (state_d == CHANGE) ? changeCoinNext : 8'd0;
    busy_d        = (state_d == VEND) || (state_d == CHANGE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      tcnt_q        <= '0;
      coin_accept_q <= 1'b0;
      coin_reject_q <= 1'b0;
      err_q         <= 1'b0;
      vend_req_q    <= 1'b0;
      vend_item_q   <= '0;
      change_req_q  <= 1'b0;
      change_coin_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      tcnt_q        <= tcnt_d;
      coin_accept_q <= coin_accept_d;
      coin_reject_q <= coin_reject_d;
      err_q         <= err_d;
      vend_req_q    <= vend_req_d;
      vend_item_q   <= vend_item_d;
      change_req_q  <= change_req_d;
      change_coin_q <= change_coin_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.coin_accept      = coin_accept_q;
  assign bus.coin_reject      = coin_reject_q;
  assign bus.err_insufficient = err_q;
  assign bus.vend_req         = vend_req_q;
  assign bus.vend_item        = vend_item_q;
  assign bus.change_req       = change_req_q;
  assign bus.change_coin      = change_coin_q;
  assign bus.credit           = credit_q;
  assign bus.busy             = busy_q;

endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
Transaction sequencer for the 4-item vending datapath. It accumulates coin credit across multiple insertions and arbitrates between select, cancel and timeout events. It drives a dispense handshake to the item mechanism, then pays change coin-by-coin through a change-hopper handshake. It sits between the coin acceptor / keypad front end and the dispenser and hopper actuators.

Parameters:
PRICE_CHOC, 8'd5, price of item 2'b00 in ₹
PRICE_CHIPS, 8'd10, price of item 2'b01 in ₹
PRICE_DRINK, 8'd20, price of item 2'b10 in ₹
PRICE_ICE, 8'd50, price of item 2'b11 in ₹
TIMEOUT_CYCLES, 1000, idle cycles in CREDIT before auto-refund (must be >= 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
coin_valid  input  1  one-cycle strobe: coin present
coin_value  input  8  coin amount in ₹, sampled with coin_valid
select_valid  input  1  one-cycle strobe: item chosen
select  input  2  item code (00 choc, 01 chips, 10 drink, 11 ice cream)
cancel  input  1  one-cycle strobe: refund request
vend_done  input  1  dispenser finished
change_ack  input  1  hopper ejected the requested coin
coin_accept  output  1  one-cycle pulse: coin credited
coin_reject  output  1  one-cycle pulse: coin refused
err_insufficient  output  1  one-cycle pulse: select refused, credit too low
vend_req  output  1  dispense request, level
vend_item  output  4  one-hot item (0001/0010/0100/1000), valid while vend_req
change_req  output  1  change coin request, level
change_coin  output  8  denomination requested, valid while change_req
credit  output  8  current credit in ₹
busy  output  1  high in VEND or CHANGE

Behaviour:
- Clock and reset: clk, synchronous active-high rst.
- Registered outputs: all outputs are registered.
- Reset values: every output, the credit register and the timeout counter are 0; state is IDLE.
- Reset mid-operation: rst asserted in any state clears all of the above at the next edge. Credit is discarded, and no in-flight handshake is completed.
- States: IDLE, CREDIT, VEND, CHANGE.
- Coin acceptance (IDLE/CREDIT only):
  - coin_valid with coin_value != 0 and credit + coin_value <= 255 (9-bit compare): credit += coin_value, coin_accept pulses next cycle.
  - Otherwise coin_reject pulses next cycle and credit is unchanged.
  - coin_valid with coin_value == 0 is ignored, with no pulse.
- Coins in VEND/CHANGE: coin_valid produces coin_reject.
- IDLE -> CREDIT on an accepted coin.
- CREDIT event priority in one cycle: cancel > select_valid > coin_valid. When a higher-priority event wins, a same-cycle coin gets coin_reject.
  - cancel: go to CHANGE if credit != 0, else IDLE.
  - select_valid with credit >= price[select]: credit -= price, vend_item latched, go to VEND. vend_req rises the cycle after select_valid (latency 1).
  - select_valid with credit < price: err_insufficient pulses next cycle, stay in CREDIT, credit unchanged.
- Timeout counter: reset by any cancel, select or coin event; increments otherwise in CREDIT. On reaching TIMEOUT_CYCLES-1, go to CHANGE (full refund).
- select_valid or cancel in IDLE, VEND or CHANGE: ignored.
- VEND:
  - vend_req and vend_item are held stable until vend_done is sampled high.
  - On that edge vend_req and vend_item go to 0, and the state moves to CHANGE if credit != 0, else IDLE.
- CHANGE:
  - change_coin is the greedy largest of {20,10,5,2,1} that is <= credit; change_req is high.
  - change_req and change_coin are held stable until change_ack.
  - On ack: credit -= change_coin. If the new credit is 0, drop change_req and go to IDLE. Otherwise present the next coin the following cycle (change_req stays high, value updates).
- Spurious handshakes: vend_done outside VEND and change_ack outside CHANGE are ignored.
- Credit bounds: credit never wraps; it is bounded 0..255 by construction.

Decomposition:
- Package vend_pkg:
  - price constants;
  - item codes 2'b00..2'b11;
  - one-hot item encodings;
  - state enum (IDLE, CREDIT, VEND, CHANGE);
  - change denomination list {20,10,5,2,1}.
- Sub-module vend_change_sel: combinational greedy denomination picker, credit[7:0] -> coin[7:0]. It is instantiated once and unit-tested separately.
- The controller holds the FSM, credit, timeout counter and output registers.

Test Plan:
- Coins 10, 10 then select 01: two coin_accept pulses, credit 20. vend_req=1 with vend_item 0010 the cycle after select; credit 10. vend_done, then change_req with coin 10; ack, then credit 0, busy 0, IDLE.
- Coin 5, select 10: err_insufficient pulse, credit stays 5. Then cancel: change_coin 5; ack, then IDLE.
- Coins 200, 50, then 10: the third coin gets coin_reject and credit stays 250. Select 11, vend_done, then change_coin sequence 20,20,20,20,20,20,20,20,20,20 (200 total).
- Coin 50, select 00, vend_done: change_coin sequence 20, 20, 5, each held until ack; a 3-cycle ack delay keeps the value stable.
- Coin 7 with no further events: CHANGE entered TIMEOUT_CYCLES cycles after the coin edge; change_coin sequence 5, 2. Also, cancel and select_valid in the same cycle (credit 10): cancel wins and no vend_req.
- rst asserted during VEND (vend_req=1) and again during CHANGE: next cycle all outputs and credit are 0 and the state is IDLE; a later vend_done or change_ack has no effect.
